// File: rtl/wb_commit_queue.sv
// Writeback commit queue: buffers MEM results (with load extension) and drains them in order to the register file.
// Latency: a push at edge N into an empty queue drives RegWrite during the cycle after N.
// Backpressure: m_ready is registered (!full); hold freezes draining, flush empties the queue and drops a same-edge push.
module wb_commit_queue #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic              m_reg_write,
  input  logic              m_mem_to_reg,
  input  logic [ADDR_W-1:0] m_rd,
  input  logic [DATA_W-1:0] m_alu_result,
  input  logic [DATA_W-1:0] m_mem_data,
  input  logic [1:0]        m_load_size,
  input  logic              m_load_signed,
  input  logic              hold,
  input  logic              flush,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic [31:0]       retire_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  typedef struct packed {
    logic              reg_write;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           q [DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr, wr_next, rd_next;
  logic             empty, full_next, push, pop;
  entry_t           head, new_entry;

  // Load data is narrowed and extended once, at push time, so the drain side stays a plain mux.
  function automatic logic [DATA_W-1:0] ext(input logic [DATA_W-1:0] d, input logic [1:0] sz,
                                            input logic sgn);
    logic [DATA_W-1:0] r;
    case (sz)
      2'b00:   r = {{(DATA_W-8){sgn & d[7]}}, d[7:0]};
      2'b01:   r = {{(DATA_W-16){sgn & d[15]}}, d[15:0]};
      2'b10:   r = {{(DATA_W-32){sgn & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign push  = m_valid & m_ready & ~flush;
  assign pop   = ~empty & ~hold & ~flush;
  assign head  = q[rd_ptr[PTR_W-1:0]];

  // Build the entry to store and the post-edge pointers (flush wins over push/pop).
  always_comb begin
    new_entry.reg_write = m_reg_write;
    new_entry.rd        = m_rd;
    new_entry.data      = m_mem_to_reg ? ext(m_mem_data, m_load_size, m_load_signed) : m_alu_result;
    wr_next = wr_ptr;
    rd_next = rd_ptr;
    if (flush) begin
      wr_next = '0;
      rd_next = '0;
    end else begin
      if (push) wr_next = wr_ptr + 1'b1;
      if (pop)  rd_next = rd_ptr + 1'b1;
    end
    full_next = (wr_next[PTR_W] != rd_next[PTR_W]) &&
                (wr_next[PTR_W-1:0] == rd_next[PTR_W-1:0]);
  end

  // Queue storage, pointers, registered ready and the retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      m_ready      <= 1'b1;
      retire_count <= '0;
    end else begin
      if (push) q[wr_ptr[PTR_W-1:0]] <= new_entry;
      wr_ptr  <= wr_next;
      rd_ptr  <= rd_next;
      m_ready <= ~full_next;
      if (pop) retire_count <= retire_count + 32'd1;
    end
  end

  // Register file port driven straight from the head entry; suppressed for no-write and zero-register entries.
  always_comb begin
    WriteReg  = empty ? '0 : head.rd;
    WriteData = empty ? '0 : head.data;
    RegWrite  = ~empty & head.reg_write & (head.rd != ZERO_IDX) & ~hold & ~flush;
  end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue: load-extension vector table plus sequences for zero-reg, hold, flush, reset and counter wrap.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every register-file write is checked against a scoreboard filled when pushes are driven.
module tb_wb_commit_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid, m_ready, m_reg_write, m_mem_to_reg, m_load_signed, hold, flush;
  logic [4:0]  m_rd;
  logic [63:0] m_alu_result, m_mem_data;
  logic [1:0]  m_load_size;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;
  logic [31:0] retire_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        m2r;
    logic [1:0]  sz;
    logic        sgn;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic [63:0] mem;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];

  wb_commit_queue #(.DATA_W(64), .ADDR_W(5), .DEPTH(2), .ZERO_REG(0)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_ready(m_ready), .m_reg_write(m_reg_write), .m_mem_to_reg(m_mem_to_reg),
    .m_rd(m_rd), .m_alu_result(m_alu_result), .m_mem_data(m_mem_data),
    .m_load_size(m_load_size), .m_load_signed(m_load_signed),
    .hold(hold), .flush(flush),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called 1 unit after a rising edge; returns 1 unit after the edge that samples the push.
  task automatic push(input logic rw, input logic m2r, input logic [4:0] rd, input logic [63:0] alu,
                      input logic [63:0] mem, input logic [1:0] sz, input logic sg,
                      input logic [63:0] exp);
    m_valid = 1'b1; m_reg_write = rw; m_mem_to_reg = m2r; m_rd = rd;
    m_alu_result = alu; m_mem_data = mem; m_load_size = sz; m_load_signed = sg;
    if (m_ready && !flush && rw && rd != 5'd0) sb.push_back('{rd, exp});
    @(posedge clk); #1;
    m_valid = 1'b0;
  endtask

  // Every observed write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (reset && RegWrite) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write: got rd %0d data %h want no write", WriteReg, WriteData);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("write_reg", 64'(WriteReg), 64'(e.rd));
        chk("write_data", WriteData, e.data);
      end
    end
  end

  initial begin
    vecs[0] = '{1'b0, 2'b11, 1'b0, 5'd3,  64'h1234, 64'hDEAD, 64'h1234};
    vecs[1] = '{1'b1, 2'b00, 1'b1, 5'd4,  64'h0, 64'h80FF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{1'b1, 2'b01, 1'b0, 5'd5,  64'h0, 64'h80FF, 64'h0000_0000_0000_80FF};
    vecs[3] = '{1'b1, 2'b10, 1'b1, 5'd6,  64'h0, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000};
    vecs[4] = '{1'b1, 2'b00, 1'b0, 5'd7,  64'h0, 64'h80FF, 64'h0000_0000_0000_00FF};
    vecs[5] = '{1'b1, 2'b01, 1'b1, 5'd8,  64'h0, 64'h80FF, 64'hFFFF_FFFF_FFFF_80FF};
    vecs[6] = '{1'b1, 2'b10, 1'b0, 5'd9,  64'h0, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000};
    vecs[7] = '{1'b1, 2'b11, 1'b1, 5'd10, 64'h0, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};

    reset = 1'b0; m_valid = 1'b0; m_reg_write = 1'b0; m_mem_to_reg = 1'b0; m_rd = '0;
    m_alu_result = '0; m_mem_data = '0; m_load_size = '0; m_load_signed = 1'b0;
    hold = 1'b0; flush = 1'b0;
    #12;
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_writedata", WriteData, 64'd0);
    chk("rst_ready", 64'(m_ready), 64'd1);
    chk("rst_retire", 64'(retire_count), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Extension table: each entry pushed into an empty queue, visible the next cycle.
    for (int i = 0; i < 8; i++) begin
      push(1'b1, vecs[i].m2r, vecs[i].rd, vecs[i].alu, vecs[i].mem, vecs[i].sz, vecs[i].sgn, vecs[i].exp);
      @(negedge clk);
      chk($sformatf("vec%0d_regwrite", i), 64'(RegWrite), 64'd1);
      chk($sformatf("vec%0d_reg", i), 64'(WriteReg), 64'(vecs[i].rd));
      chk($sformatf("vec%0d_data", i), WriteData, vecs[i].exp);
      @(posedge clk); #1;
    end
    chk("retire_after_table", 64'(retire_count), 64'd8);

    // Zero register and no-write entries pop and count but never write.
    push(1'b1, 1'b0, 5'd0, 64'h77, 64'h0, 2'b11, 1'b0, 64'h77);
    @(negedge clk); chk("zero_reg_nowrite", 64'(RegWrite), 64'd0);
    @(posedge clk); #1;
    push(1'b0, 1'b0, 5'd5, 64'h88, 64'h0, 2'b11, 1'b0, 64'h88);
    @(negedge clk); chk("rw0_nowrite", 64'(RegWrite), 64'd0);
    @(posedge clk); #1;
    chk("retire_after_zero", 64'(retire_count), 64'd10);

    // Hold with three back-to-back pushes: third stalls, then all drain in order.
    hold = 1'b1;
    push(1'b1, 1'b0, 5'd11, 64'hA, 64'h0, 2'b11, 1'b0, 64'hA);
    push(1'b1, 1'b0, 5'd12, 64'hB, 64'h0, 2'b11, 1'b0, 64'hB);
    m_valid = 1'b1; m_reg_write = 1'b1; m_mem_to_reg = 1'b0; m_rd = 5'd13; m_alu_result = 64'hC;
    chk("full_ready_low", 64'(m_ready), 64'd0);
    @(posedge clk); #1;
    chk("stalled_ready_low", 64'(m_ready), 64'd0);
    @(negedge clk); chk("hold_nowrite", 64'(RegWrite), 64'd0);
    @(posedge clk); #1;
    hold = 1'b0;
    begin
      logic accepted = 1'b0;
      for (int k = 0; k < 10 && !accepted; k++) begin
        if (m_ready) begin
          sb.push_back('{5'd13, 64'hC});
          accepted = 1'b1;
        end
        @(posedge clk); #1;
      end
      m_valid = 1'b0;
      chk("stalled_push_accepted", 64'(accepted), 64'd1);
    end
    repeat (4) @(posedge clk); #1;
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("retire_after_hold", 64'(retire_count), 64'd13);

    // Flush with two queued and a concurrent push.
    hold = 1'b1;
    push(1'b1, 1'b0, 5'd20, 64'h20, 64'h0, 2'b11, 1'b0, 64'h20);
    push(1'b1, 1'b0, 5'd21, 64'h21, 64'h0, 2'b11, 1'b0, 64'h21);
    sb.delete();
    hold = 1'b0; flush = 1'b1;
    m_valid = 1'b1; m_rd = 5'd22; m_alu_result = 64'h22;
    @(negedge clk); chk("flush_nowrite", 64'(RegWrite), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; m_valid = 1'b0;
    chk("flush_ready", 64'(m_ready), 64'd1);
    chk("flush_empty_data", WriteData, 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("flush_retire", 64'(retire_count), 64'd13);

    // Flush beats both hold and a push that would otherwise be accepted.
    hold = 1'b1;
    push(1'b1, 1'b0, 5'd23, 64'h23, 64'h0, 2'b11, 1'b0, 64'h23);
    sb.delete();
    flush = 1'b1;
    push(1'b1, 1'b0, 5'd24, 64'h24, 64'h0, 2'b11, 1'b0, 64'h24);
    flush = 1'b0; hold = 1'b0;
    chk("flush2_empty_data", WriteData, 64'd0);
    chk("flush2_ready", 64'(m_ready), 64'd1);
    repeat (3) @(posedge clk); #1;
    chk("flush2_retire", 64'(retire_count), 64'd13);

    // Reset asserted mid-drain with two queued.
    hold = 1'b1;
    push(1'b1, 1'b0, 5'd1, 64'h101, 64'h0, 2'b11, 1'b0, 64'h101);
    push(1'b1, 1'b0, 5'd2, 64'h102, 64'h0, 2'b11, 1'b0, 64'h102);
    hold = 1'b0;
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midrst_regwrite", 64'(RegWrite), 64'd0);
    chk("midrst_writereg", 64'(WriteReg), 64'd0);
    chk("midrst_writedata", WriteData, 64'd0);
    chk("midrst_ready", 64'(m_ready), 64'd1);
    chk("midrst_retire", 64'(retire_count), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("postrst_retire", 64'(retire_count), 64'd0);

    // Counter wrap from all-ones to zero.
    force dut.retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count;
    chk("wrap_preload", 64'(retire_count), 64'hFFFF_FFFF);
    push(1'b1, 1'b0, 5'd7, 64'h55, 64'h0, 2'b11, 1'b0, 64'h55);
    @(posedge clk); #1;
    chk("wrap_zero", 64'(retire_count), 64'd0);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
